// File: rtl/ysyx_23060111_lsu_if.sv
// Word-aligned req/gnt/rvalid memory bus between the LSU (master) and memory (slave).
interface ysyx_23060111_lsu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        wstrb;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, wstrb, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, wstrb, output gnt, rvalid, rdata);
endinterface

// File: rtl/ysyx_23060111_lsu.sv
// Load/store unit: one memory op per handshake, byte-lane alignment, single bus
// request, load extension, result handed to writeback over valid/ready.
module ysyx_23060111_lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_ren,
  input  logic                in_wen,
  input  logic [2:0]          in_funct3,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [DATA_W-1:0]   in_wdata,
  ysyx_23060111_lsu_if.master mem,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_rdata,
  output logic                out_is_load,
  output logic                out_err
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_r;
  logic              in_ready_r;
  logic              mem_req_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic [3:0]        mem_wstrb_r;
  logic              ren_r;
  logic [2:0]        funct3_r;
  logic [1:0]        off_r;
  logic              out_valid_r;
  logic              out_is_load_r;
  logic              out_err_r;
  logic [DATA_W-1:0] out_rdata_r;

  logic              err_s;
  logic [3:0]        wstrb_s;
  logic [DATA_W-1:0] wdata_s;
  logic [DATA_W-1:0] shifted_s;
  logic [DATA_W-1:0] load_s;

  // Misaligned access, unsupported size/sign code, unsigned store, or load+store together.
  function automatic logic op_illegal(input logic ren, input logic wen,
                                      input logic [2:0] funct3, input logic [1:0] off);
    logic bad;
    case (funct3)
      3'b000:  bad = 1'b0;
      3'b001:  bad = off[0];
      3'b010:  bad = (off != 2'b00);
      3'b100:  bad = wen;
      3'b101:  bad = wen | off[0];
      default: bad = 1'b1;
    endcase
    return bad | (ren & wen);
  endfunction

  // Store lane placement and error decode for the op being offered.
  always_comb begin
    err_s   = op_illegal(in_ren, in_wen, in_funct3, in_addr[1:0]);
    wstrb_s = 4'b0000;
    wdata_s = in_wdata;
    case (in_funct3[1:0])
      2'b00: begin
        wstrb_s = 4'b0001 << in_addr[1:0];
        wdata_s = {4{in_wdata[7:0]}};
      end
      2'b01: begin
        wstrb_s = 4'b0011 << in_addr[1:0];
        wdata_s = {2{in_wdata[15:0]}};
      end
      2'b10: begin
        wstrb_s = 4'b1111;
        wdata_s = in_wdata;
      end
      default: begin
        wstrb_s = 4'b0000;
        wdata_s = in_wdata;
      end
    endcase
  end

  // Load extraction from the returned word using the latched offset and size.
  always_comb begin
    shifted_s = mem.rdata >> {off_r, 3'b000};
    case (funct3_r)
      3'b000:  load_s = {{24{shifted_s[7]}}, shifted_s[7:0]};
      3'b100:  load_s = {24'h000000, shifted_s[7:0]};
      3'b001:  load_s = {{16{shifted_s[15]}}, shifted_s[15:0]};
      3'b101:  load_s = {16'h0000, shifted_s[15:0]};
      default: load_s = shifted_s;
    endcase
  end

  // Transaction FSM with all outward-facing signals registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= S_IDLE;
      in_ready_r    <= 1'b1;
      mem_req_r     <= 1'b0;
      mem_we_r      <= 1'b0;
      mem_addr_r    <= {ADDR_W{1'b0}};
      mem_wdata_r   <= {DATA_W{1'b0}};
      mem_wstrb_r   <= 4'b0000;
      ren_r         <= 1'b0;
      funct3_r      <= 3'b000;
      off_r         <= 2'b00;
      out_valid_r   <= 1'b0;
      out_is_load_r <= 1'b0;
      out_err_r     <= 1'b0;
      out_rdata_r   <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (in_valid) begin
            in_ready_r <= 1'b0;
            ren_r      <= in_ren;
            funct3_r   <= in_funct3;
            off_r      <= in_addr[1:0];
            if ((!in_ren && !in_wen) || err_s) begin
              // No-ops and illegal ops complete without touching the bus.
              state_r       <= S_DONE;
              out_valid_r   <= 1'b1;
              out_is_load_r <= in_ren;
              out_err_r     <= in_ren | in_wen;
              out_rdata_r   <= {DATA_W{1'b0}};
            end else begin
              state_r     <= S_REQ;
              mem_req_r   <= 1'b1;
              mem_we_r    <= in_wen;
              mem_addr_r  <= {in_addr[ADDR_W-1:2], 2'b00};
              mem_wdata_r <= wdata_s;
              mem_wstrb_r <= in_wen ? wstrb_s : 4'b0000;
            end
          end
        end
        S_REQ: begin
          if (mem.gnt) begin
            mem_req_r <= 1'b0;
            if (mem.rvalid) begin
              state_r       <= S_DONE;
              out_valid_r   <= 1'b1;
              out_is_load_r <= ren_r;
              out_err_r     <= 1'b0;
              out_rdata_r   <= ren_r ? load_s : {DATA_W{1'b0}};
            end else begin
              state_r <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (mem.rvalid) begin
            state_r       <= S_DONE;
            out_valid_r   <= 1'b1;
            out_is_load_r <= ren_r;
            out_err_r     <= 1'b0;
            out_rdata_r   <= ren_r ? load_s : {DATA_W{1'b0}};
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_r       <= S_IDLE;
            in_ready_r    <= 1'b1;
            out_valid_r   <= 1'b0;
            out_is_load_r <= 1'b0;
            out_err_r     <= 1'b0;
            out_rdata_r   <= {DATA_W{1'b0}};
          end
        end
        default: begin
          state_r     <= S_IDLE;
          in_ready_r  <= 1'b1;
          mem_req_r   <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_r;
  assign mem.req     = mem_req_r;
  assign mem.we      = mem_we_r;
  assign mem.addr    = mem_addr_r;
  assign mem.wdata   = mem_wdata_r;
  assign mem.wstrb   = mem_wstrb_r;
  assign out_valid   = out_valid_r;
  assign out_rdata   = out_rdata_r;
  assign out_is_load = out_is_load_r;
  assign out_err     = out_err_r;
endmodule

// File: doc/ysyx_23060111_lsu.md
Name: ysyx_23060111_lsu

Overview:
Load/store unit directly downstream of the execute stage. Accepts one memory operation per handshake: address, store data, funct3 and load/store enables. Performs byte-lane alignment, issues a single word-aligned request on a req/gnt/rvalid memory bus, then sign- or zero-extends load data. Presents the result to writeback through a valid/ready handshake.

Parameters:
ADDR_W, 32, width of byte address and mem_addr
DATA_W, 32, data width; fixed 32, four byte lanes

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  EXU presents an operation
in_ready  out  1  LSU can accept; high only in IDLE
in_ren  in  1  load
in_wen  in  1  store
in_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
in_addr  in  ADDR_W  byte address
in_wdata  in  DATA_W  store data, LSB-justified
mem_req  out  1  bus request, held until mem_gnt
mem_we  out  1  1 = write
mem_addr  out  ADDR_W  {in_addr[31:2],2'b00}
mem_wdata  out  DATA_W  store data shifted to byte lane
mem_wstrb  out  4  byte strobes; 0 for reads
mem_gnt  in  1  bus accepted request
mem_rvalid  in  1  read data / write completion
mem_rdata  in  DATA_W  read word
out_valid  out  1  result valid to WBU
out_ready  in  1  WBU accepts
out_rdata  out  DATA_W  extended load data; 0 for stores and no-ops
out_is_load  out  1  result targets rd
out_err  out  1  misaligned, illegal funct3, or ren&wen both set

Behaviour:
- Reset (async, rst_n low): state=IDLE. All outputs 0 except in_ready=1. Captured registers cleared. A transaction in flight is abandoned; mem_req drops immediately.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: in_ready=1. On in_valid: latch all inputs, then:
  - ren=wen=0 (no-op) -> DONE.
  - Error (see below) -> DONE with out_err=1; no bus access.
  - Otherwise -> REQ.
- REQ: mem_req=1, with mem_we/addr/wdata/wstrb stable from latched values.
  - mem_gnt=0 -> stay in REQ.
  - mem_gnt=1 and mem_rvalid=1 in the same cycle -> capture data, go to DONE.
  - mem_gnt=1 only -> WAIT.
- WAIT: mem_req=0. On mem_rvalid, capture mem_rdata and go to DONE. mem_rvalid in IDLE/DONE is ignored.
- DONE: out_valid=1; outputs are held stable until out_ready. On out_valid&&out_ready -> IDLE. in_ready stays low until IDLE, so there is no back-to-back overlap.
- Minimum latency, accept to out_valid:
  - No-op/error: 1 cycle.
  - Zero-wait bus (gnt and rvalid together): 2 cycles.
- Errors:
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - funct3 in {011,110,111}.
  - Store with funct3 100/101.
  - ren&wen both set.
  - out_is_load is still reported on error.
- Store lanes, with off=addr[1:0]:
  - B: wstrb=4'b0001<<off; wdata=wdata[7:0] replicated to all lanes.
  - H: wstrb=4'b0011<<off; wdata={2{wdata[15:0]}}.
  - W: wstrb=4'hF.
- Load extract: byte = rdata>>(8*off) and half = rdata>>(8*off).
  - 000: sign-extend bit 7.
  - 100: zero-extend byte.
  - 001: sign-extend bit 15.
  - 101: zero-extend half.
  - 010: full word.
- out_rdata is registered, captured on the response cycle.

Test Plan:
- Store byte: SB addr=0x80000003, wdata=0x000000AB, gnt on the first REQ cycle, rvalid one cycle later -> mem_addr=0x80000000, wstrb=4'b1000, wdata=0xABABABAB; out_valid 3 cycles after accept; out_rdata=0, out_err=0.
- Load signed/unsigned byte: LB addr=0x80000002, rdata=0x12F45678 -> out_rdata=0xFFFFFFF4. Same with LBU -> 0x000000F4.
- Load half, delayed grant, back-pressure: LHU addr=0x80000002, rdata=0x8001_0000, gnt held off 3 cycles, out_ready low 2 cycles -> mem_req stays high 4 cycles with address stable; out_rdata=0x00008001 held until out_ready; in_ready=0 throughout.
- Misaligned: LW addr=0x80000001 -> no mem_req ever; out_valid next cycle with out_err=1.
- ren&wen both set -> same as misaligned: no mem_req, out_err=1 next cycle.
- Zero-wait bus and reset mid-flight: LW with gnt and rvalid in the same cycle, rdata=0xDEADBEEF -> out_valid on the next cycle with out_rdata=0xDEADBEEF. Separately, drop rst_n while in WAIT -> mem_req/out_valid=0 and in_ready=1 asynchronously; a later stray mem_rvalid causes no out_valid.
